// File: rtl/glyph_string_plotter.sv
// glyph_string_plotter
// Sequential text renderer. Walks each glyph cell of a latched string pixel by
// pixel, asks an external combinational glyph lookup whether the pixel is lit,
// and issues one registered plot request per plotted pixel over valid/ready.
//
// Optional feature macro: GLYPH_BG_FILL_EN
//   defined   : every cell pixel is plotted (unlit pixels use bg_colour)
//   undefined : unlit pixels are skipped, bg_colour is ignored
//
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   start                 render request, sampled only while idle
//   origin_x, origin_y    top-left pixel of char 0
//   chars, length         packed glyph codes and string length (clamped)
//   colour, bg_colour     foreground / background colour
//   q_code, q_gx, q_gy    glyph lookup query (combinational)
//   q_pixel               glyph lookup answer, same cycle
//   plot_valid/ready      plot request handshake
//   plot_x/y/colour       registered plot payload
//   busy                  high while scanning or emitting
//   done                  one-cycle pulse at end of render
module glyph_string_plotter #(
  parameter int unsigned GLYPH_W    = 8,
  parameter int unsigned GLYPH_H    = 10,
  parameter int unsigned CHAR_PITCH = 10,
  parameter int unsigned MAX_CHARS  = 8,
  parameter int unsigned CODE_W     = 6
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [7:0]                           origin_x,
  input  logic [7:0]                           origin_y,
  input  logic [MAX_CHARS*CODE_W-1:0]          chars,
  input  logic [$clog2(MAX_CHARS+1)-1:0]       length,
  input  logic [5:0]                           colour,
  input  logic [5:0]                           bg_colour,
  output logic [CODE_W-1:0]                    q_code,
  output logic [7:0]                           q_gx,
  output logic [7:0]                           q_gy,
  input  logic                                 q_pixel,
  output logic                                 plot_valid,
  input  logic                                 plot_ready,
  output logic [7:0]                           plot_x,
  output logic [7:0]                           plot_y,
  output logic [5:0]                           plot_colour,
  output logic                                 busy,
  output logic                                 done
);

  localparam int unsigned LEN_W  = $clog2(MAX_CHARS + 1);
  localparam int unsigned CI_W   = (MAX_CHARS > 1) ? $clog2(MAX_CHARS) : 1;
  localparam int unsigned GX_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned GY_W   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned CHAR_W = MAX_CHARS * CODE_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_EMIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state, state_n;
  logic [CI_W-1:0]   ci, ci_n, ci_adv;
  logic [GX_W-1:0]   gx, gx_n, gx_adv;
  logic [GY_W-1:0]   gy, gy_n, gy_adv;
  logic [7:0]        ox_r, ox_n, oy_r, oy_n;
  logic [CHAR_W-1:0] chars_r, chars_n;
  logic [LEN_W-1:0]  len_r, len_n, len_clamped;
  logic [5:0]        col_r, col_n, bg_r, bg_n;
  logic              valid_n, busy_n, done_n;
  logic [7:0]        x_n, y_n;
  logic [5:0]        pcol_n;
  logic              last_pos, hit;
  logic [5:0]        hit_colour;

  // Query the lookup directly from the scan counters.
  assign q_code = chars_r[ci*CODE_W +: CODE_W];
  assign q_gx   = 8'(gx);
  assign q_gy   = 8'(gy);

  assign len_clamped = (length > LEN_W'(MAX_CHARS)) ? LEN_W'(MAX_CHARS) : length;

  // Plot decision: fill mode plots every pixel, otherwise only lit ones.
`ifdef GLYPH_BG_FILL_EN
  assign hit        = 1'b1;
  assign hit_colour = q_pixel ? col_r : bg_r;
`else
  logic unused_bg;
  assign unused_bg  = ^{bg_colour, bg_r};
  assign hit        = q_pixel;
  assign hit_colour = col_r;
`endif

  assign last_pos = (gx == GX_W'(GLYPH_W - 1)) &&
                    (gy == GY_W'(GLYPH_H - 1)) &&
                    ((LEN_W'(ci) + LEN_W'(1)) == len_r);

  // Counter advance: gx fastest, then gy, then ci.
  always_comb begin
    gx_adv = gx + GX_W'(1);
    gy_adv = gy;
    ci_adv = ci;
    if (gx == GX_W'(GLYPH_W - 1)) begin
      gx_adv = '0;
      if (gy == GY_W'(GLYPH_H - 1)) begin
        gy_adv = '0;
        ci_adv = ci + CI_W'(1);
      end else begin
        gy_adv = gy + GY_W'(1);
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_n = state;
    ci_n    = ci;
    gx_n    = gx;
    gy_n    = gy;
    ox_n    = ox_r;
    oy_n    = oy_r;
    chars_n = chars_r;
    len_n   = len_r;
    col_n   = col_r;
    bg_n    = bg_r;
    valid_n = plot_valid;
    x_n     = plot_x;
    y_n     = plot_y;
    pcol_n  = plot_colour;

    case (state)
      S_IDLE: begin
        if (start) begin
          ox_n    = origin_x;
          oy_n    = origin_y;
          chars_n = chars;
          len_n   = len_clamped;
          col_n   = colour;
          bg_n    = bg_colour;
          ci_n    = '0;
          gx_n    = '0;
          gy_n    = '0;
          state_n = (len_clamped == '0) ? S_DONE : S_SCAN;
        end
      end
      S_SCAN: begin
        if (hit) begin
          x_n     = ox_r + 8'(32'(ci) * CHAR_PITCH) + 8'(gx);
          y_n     = oy_r + 8'(gy);
          pcol_n  = hit_colour;
          valid_n = 1'b1;
          state_n = S_EMIT;
        end else if (last_pos) begin
          state_n = S_DONE;
        end else begin
          ci_n = ci_adv;
          gx_n = gx_adv;
          gy_n = gy_adv;
        end
      end
      S_EMIT: begin
        if (plot_ready) begin
          valid_n = 1'b0;
          if (last_pos) begin
            state_n = S_DONE;
          end else begin
            ci_n    = ci_adv;
            gx_n    = gx_adv;
            gy_n    = gy_adv;
            state_n = S_SCAN;
          end
        end
      end
      default: begin
        ci_n    = '0;
        gx_n    = '0;
        gy_n    = '0;
        state_n = S_IDLE;
      end
    endcase

    busy_n = (state_n == S_SCAN) || (state_n == S_EMIT);
    done_n = (state_n == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ci          <= '0;
      gx          <= '0;
      gy          <= '0;
      ox_r        <= '0;
      oy_r        <= '0;
      chars_r     <= '0;
      len_r       <= '0;
      col_r       <= '0;
      bg_r        <= '0;
      plot_valid  <= 1'b0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_n;
      ci          <= ci_n;
      gx          <= gx_n;
      gy          <= gy_n;
      ox_r        <= ox_n;
      oy_r        <= oy_n;
      chars_r     <= chars_n;
      len_r       <= len_n;
      col_r       <= col_n;
      bg_r        <= bg_n;
      plot_valid  <= valid_n;
      plot_x      <= x_n;
      plot_y      <= y_n;
      plot_colour <= pcol_n;
      busy        <= busy_n;
      done        <= done_n;
    end
  end

endmodule

// File: tb/tb_glyph_string_plotter.sv
// Scoreboard bench for glyph_string_plotter: a glyph ROM model answers the
// lookup, a reference walk of the string queues expected plots, and a monitor
// pops and compares on every accepted plot request.
module tb_glyph_string_plotter;

  localparam int unsigned GW    = 8;
  localparam int unsigned GH    = 10;
  localparam int unsigned PITCH = 10;
  localparam int unsigned MAXC  = 8;
  localparam int unsigned CW    = 6;
  localparam logic [5:0]  K_CODE = 6'd11;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } plot_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  origin_x = '0;
  logic [7:0]  origin_y = '0;
  logic [47:0] chars = '0;
  logic [3:0]  length = '0;
  logic [5:0]  colour = '0;
  logic [5:0]  bg_colour = '0;
  logic [5:0]  q_code;
  logic [7:0]  q_gx, q_gy;
  logic        q_pixel;
  logic        plot_valid;
  logic        plot_ready = 1'b1;
  logic [7:0]  plot_x, plot_y;
  logic [5:0]  plot_colour;
  logic        busy, done;

  plot_t exp_q[$];
  int total = 0;
  int bad = 0;
  int seen = 0;
  int done_cnt = 0;
  bit busy_seen = 0;

  always #5 clk = ~clk;

  glyph_string_plotter dut (
    .clock(clk), .reset(rst), .start(start),
    .origin_x(origin_x), .origin_y(origin_y), .chars(chars), .length(length),
    .colour(colour), .bg_colour(bg_colour),
    .q_code(q_code), .q_gx(q_gx), .q_gy(q_gy), .q_pixel(q_pixel),
    .plot_valid(plot_valid), .plot_ready(plot_ready),
    .plot_x(plot_x), .plot_y(plot_y), .plot_colour(plot_colour),
    .busy(busy), .done(done)
  );

  // "K" bitmap, bit n of a row = column n; 21 lit pixels.
  function automatic logic [7:0] k_row(input int gy);
    case (gy)
      0: return 8'h84;
      1: return 8'h44;
      2: return 8'h24;
      3: return 8'h14;
      4: return 8'h0C;
      5: return 8'h1C;
      6: return 8'h14;
      7: return 8'h24;
      8: return 8'h44;
      9: return 8'h84;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic glyph_px(input logic [5:0] code, input int gx, input int gy);
    logic [7:0] row;
    if (code != K_CODE || gx >= int'(GW) || gy >= int'(GH)) return 1'b0;
    row = k_row(gy);
    return row[gx];
  endfunction

  always_comb q_pixel = glyph_px(q_code, int'(q_gx), int'(q_gy));

  task automatic check(input string name, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference walk: queue the plots the string should produce.
  task automatic model_push(input logic [7:0] ox, input logic [7:0] oy, input logic [47:0] ch,
                            input logic [3:0] len, input logic [5:0] col, input logic [5:0] bg,
                            output int n);
    int L;
    logic [5:0] code;
    logic lit;
    plot_t p;
    n = 0;
    L = (int'(len) > int'(MAXC)) ? int'(MAXC) : int'(len);
    for (int ci = 0; ci < L; ci++) begin
      code = ch[ci*CW +: CW];
      for (int gy = 0; gy < int'(GH); gy++) begin
        for (int gx = 0; gx < int'(GW); gx++) begin
          lit = glyph_px(code, gx, gy);
`ifdef GLYPH_BG_FILL_EN
          p.x = 8'(int'(ox) + ci*int'(PITCH) + gx);
          p.y = 8'(int'(oy) + gy);
          p.c = lit ? col : bg;
          exp_q.push_back(p);
          n++;
`else
          if (lit) begin
            p.x = 8'(int'(ox) + ci*int'(PITCH) + gx);
            p.y = 8'(int'(oy) + gy);
            p.c = col;
            exp_q.push_back(p);
            n++;
          end
`endif
        end
      end
    end
  endtask

  task automatic start_render(input logic [7:0] ox, input logic [7:0] oy, input logic [47:0] ch,
                              input logic [3:0] len, input logic [5:0] col, input logic [5:0] bg,
                              output int n);
    model_push(ox, oy, ch, len, col, bg, n);
    seen = 0;
    done_cnt = 0;
    busy_seen = 0;
    origin_x = ox;
    origin_y = oy;
    chars = ch;
    length = len;
    colour = col;
    bg_colour = bg;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done, then check totals. cyc counts from the start edge.
  task automatic finish_render(input string name, input int n, output int cyc);
    cyc = 1;
    while (!done && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no done expected done", name);
    end
    repeat (2) begin @(posedge clk); #1; end
    check({name, "_plots"}, seen, n);
    check({name, "_leftover"}, exp_q.size(), 0);
    check({name, "_done_pulses"}, done_cnt, 1);
  endtask

  // Monitor: compare every accepted plot against the scoreboard head.
  always @(negedge clk) begin
    plot_t e;
    if (!rst) begin
      if (busy) busy_seen = 1;
      if (done) done_cnt++;
      if (plot_valid && plot_ready) begin
        seen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL plot_extra: got (%0d,%0d,c%0d) expected none", plot_x, plot_y, plot_colour);
        end else begin
          e = exp_q.pop_front();
          if ({plot_x, plot_y, plot_colour} !== e) begin
            bad++;
            $display("FAIL plot: got (%0d,%0d,c%0d) expected (%0d,%0d,c%0d)",
                     plot_x, plot_y, plot_colour, e.x, e.y, e.c);
          end
        end
      end
    end
  end

  initial begin
    int n, cyc, k;
    plot_t fp;
    logic [47:0] kk, k8;
    kk = {36'd0, K_CODE, K_CODE};
    k8 = {8{K_CODE}};

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", int'(plot_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_x", int'(plot_x), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single K, free-running writer, cycle-exact done.
    start_render(8'd20, 8'd30, {42'd0, K_CODE}, 4'd1, 6'h2A, 6'h15, n);
    finish_render("k1", n, cyc);
    check("k1_done_cycle", cyc, 1 + int'(GW*GH) + n);

    // Two chars from origin.
    start_render(8'd0, 8'd0, kk, 4'd2, 6'h07, 6'h31, n);
    finish_render("kk", n, cyc);
    check("kk_done_cycle", cyc, 1 + 2*int'(GW*GH) + n);

    // Backpressure on the first request.
    plot_ready = 1'b0;
    start_render(8'd20, 8'd30, {42'd0, K_CODE}, 4'd1, 6'h11, 6'h22, n);
    fp = exp_q[0];
    k = 0;
    while (!plot_valid && k < 200) begin @(posedge clk); #1; k++; end
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", int'(plot_valid), 1);
      check("bp_x", int'(plot_x), int'(fp.x));
      check("bp_y", int'(plot_y), int'(fp.y));
      @(posedge clk); #1;
    end
    plot_ready = 1'b1;
    finish_render("bp", n, cyc);

    // Zero length: immediate done, never busy.
    start_render(8'd5, 8'd5, {42'd0, K_CODE}, 4'd0, 6'h01, 6'h02, n);
    finish_render("len0", n, cyc);
    check("len0_done_cycle", cyc, 1);
    check("len0_busy", int'(busy_seen), 0);

    // Over-long length clamps to MAX_CHARS.
    start_render(8'd0, 8'd100, k8, 4'd15, 6'h3F, 6'h00, n);
    finish_render("clamp", n, cyc);

    // Horizontal wrap, plus a start mid-render that must be ignored.
    start_render(8'd250, 8'd5, {42'd0, K_CODE}, 4'd1, 6'h0C, 6'h30, n);
    repeat (30) @(posedge clk);
    #1;
    chars = '0;
    origin_x = 8'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish_render("wrap", n, cyc);

    // Reset in EMIT, then a clean re-render.
    plot_ready = 1'b0;
    start_render(8'd20, 8'd30, {42'd0, K_CODE}, 4'd1, 6'h05, 6'h06, n);
    k = 0;
    while (!plot_valid && k < 200) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", int'(plot_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    plot_ready = 1'b1;
    start_render(8'd20, 8'd30, {42'd0, K_CODE}, 4'd1, 6'h05, 6'h06, n);
    finish_render("post_rst", n, cyc);
    check("post_rst_done_cycle", cyc, 1 + int'(GW*GH) + n);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glyph_string_plotter.md
Name: glyph_string_plotter

Overview:
- Sequential text renderer for the character-graphics path.
- Accepts a string of up to MAX_CHARS glyph codes plus a screen origin.
- Scans every glyph cell pixel by pixel, querying an external glyph lookup, and emits one plot request per lit pixel over a valid/ready handshake to the frame-buffer writer.
- Replaces per-character combinational decoders with one parametrised, multi-character, back-pressurable engine.

Parameters:
- GLYPH_W, 8, glyph cell width in pixels.
- GLYPH_H, 10, glyph cell height in pixels.
- CHAR_PITCH, 10, horizontal advance between consecutive characters in pixels.
- MAX_CHARS, 8, maximum string length.
- CODE_W, 6, glyph code width.

Ports:
- clock, in, 1, system clock; all state updates on the rising edge.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, request to render the string; sampled only in IDLE.
- origin_x, in, 8, x of top-left pixel of char 0.
- origin_y, in, 8, y of top-left pixel of char 0.
- chars, in, MAX_CHARS*CODE_W, packed codes; char i occupies bits [i*CODE_W +: CODE_W].
- length, in, clog2(MAX_CHARS+1), number of chars to render; values above MAX_CHARS are clamped to MAX_CHARS.
- colour, in, 6, foreground colour.
- bg_colour, in, 6, background colour; used only with BG_FILL_EN.
- q_code, out, CODE_W, glyph lookup code; combinational from internal state.
- q_gx, out, 8, glyph lookup column.
- q_gy, out, 8, glyph lookup row.
- q_pixel, in, 1, lookup result; must be combinational, valid in the same cycle as the query.
- plot_valid, out, 1, plot request valid; registered.
- plot_ready, in, 1, writer accepts the request.
- plot_x, out, 8, pixel x; registered.
- plot_y, out, 8, pixel y; registered.
- plot_colour, out, 6, pixel colour; registered.
- busy, out, 1, high in SCAN and EMIT.
- done, out, 1, one-cycle pulse when rendering completes.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; plot_valid, plot_x, plot_y, plot_colour, busy and done all 0; all counters 0; latched operands 0. Outputs recover on the first clock edge after reset deasserts.
- States: IDLE, SCAN, EMIT, DONE.
- IDLE:
  - On start=1, latch origin_x, origin_y, chars, clamped length and colour; clear ci/gx/gy.
  - Next state is SCAN, or DONE if the clamped length is 0.
  - start in any other state is ignored; it is not queued.
- SCAN: query outputs are q_code=chars[ci], q_gx=gx, q_gy=gy.
  - If q_pixel=1: register plot_x = origin_x + ci*CHAR_PITCH + gx (mod 256), plot_y = origin_y + gy (mod 256), plot_colour = colour; set plot_valid; go to EMIT. Counters do not advance.
  - If q_pixel=0: advance the counters. Go to DONE if this was the last position of the last char, else stay in SCAN.
- EMIT: plot_valid and all plot_* outputs are held stable while plot_ready=0.
  - On a cycle with plot_ready=1: the request is accepted; plot_valid drops next cycle; advance the counters. Go to DONE if this was the last position, else SCAN.
- Counter advance order: gx fastest (0..GLYPH_W-1), then gy (0..GLYPH_H-1), then ci (0..length-1).
- DONE: done=1 for exactly one cycle; busy=0; next state IDLE. A start seen in DONE is ignored.
- busy rises the cycle after start is accepted. When length=0, busy never rises and done pulses the cycle after start.
- Coordinate arithmetic is performed at 8 bits and wraps silently; there is no clipping.
- Cycle cost per char = GLYPH_W*GLYPH_H SCAN cycles + one EMIT cycle per lit pixel (when plot_ready is held at 1).

Optional Feature:
- Macro: GLYPH_BG_FILL_EN.
- Defined:
  - SCAN treats every cell pixel as plotted.
  - q_pixel=1 gives plot_colour=colour; q_pixel=0 gives plot_colour=bg_colour.
  - Every char emits exactly GLYPH_W*GLYPH_H plots, overwriting old text.
- Undefined:
  - Unlit pixels are skipped (transparent).
  - bg_colour is unused and ignored.

Test Plan:
- K glyph at (20,30), length=1, plot_ready=1 -> 21 plots. First plot is (22,30), last is (27,39). All colour=colour. done pulses on cycle 102 after the start edge (80 SCAN + 21 EMIT cycles).
- Two-char string "KK" at (0,0), plot_ready=1 -> 42 plots. The second char's first plot is (12,0). Exactly one done pulse.
- Backpressure: plot_ready=0 for 5 cycles at the first request -> plot_valid and plot_x/plot_y held at (22,30) across all 5 cycles. There are no duplicate or lost plots; the total is still 21.
- length=0 and start -> no plot_valid. busy stays 0. done pulses one cycle later. Also: length=15 with MAX_CHARS=8 -> renders 8 chars.
- Wrap and ignored start: origin_x=250 with K -> first plot x=252, the pixel at gx=7 plots at x=1. A start pulse mid-render leaves the latched chars unchanged.
- Reset asserted mid-EMIT -> plot_valid, busy and done drop to 0 immediately. After release, a fresh start renders the full glyph from (gx,gy,ci)=(0,0,0).
- With GLYPH_BG_FILL_EN defined: K glyph -> 80 plots, of which 21 carry colour and 59 carry bg_colour.
